mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter N_CH, default 3, number of requesting channels (2..8); channel 0 is CPU data, 1 is MMU walk, 2 is VGA DMA.
REQ-002 Parameter ADDR_W, default 64, byte address width.
REQ-003 Parameter DATA_W, default 64, data width.
REQ-004 Parameter RD_LAT, default 1, memory read latency in cycles (1..4).
REQ-005 Parameter MODE, default 0, arbitration policy: 0 = round-robin, 1 = fixed priority with the lowest index winning.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 hold  input  1  debug/step freeze; when high, no new grant is issued.
REQ-009 req_valid  input  N_CH  per-channel request.
REQ-010 req_we  input  N_CH  per-channel write flag.
REQ-011 req_addr  input  N_CH*ADDR_W  packed addresses; channel i occupies bits [i*ADDR_W +: ADDR_W].
REQ-012 req_wdata  input  N_CH*DATA_W  packed write data, packed the same way as req_addr.
REQ-013 req_ready  output  N_CH  one-hot acceptance of a request.
REQ-014 resp_valid  output  N_CH  one-hot completion strobe, for both reads and writes.
REQ-015 resp_rdata  output  DATA_W  read data, shared by all channels.
REQ-016 mem_we, mem_addr, mem_wdata  output  1/ADDR_W/DATA_W  single RAM port.
REQ-017 mem_rdata  input  DATA_W  RAM read data.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 grant_cnt  output  N_CH*16  per-channel saturating count of accepted requests.

Function
REQ-020 The FSM has states IDLE, ACCESS and RESP.
REQ-021 IDLE: if hold is low and any req_valid is set, assert req_ready[g] combinationally for the single winner g; the handshake completes in that cycle and the state moves to ACCESS.
REQ-022 req_ready is zero in ACCESS and RESP, and zero in IDLE whenever hold is high.
REQ-023 On the handshake, latch g, req_we[g], req_addr[g] and req_wdata[g] into internal registers.
REQ-024 ACCESS lasts exactly RD_LAT cycles, tracked by a down-counter; mem_addr and mem_wdata are driven from the latched registers for that whole window.
REQ-025 mem_we is high only in the first ACCESS cycle, and only for a write.
REQ-026 On the last ACCESS cycle, register mem_rdata into resp_rdata for a read; resp_rdata is left unchanged for a write.
REQ-027 RESP lasts one cycle: resp_valid[g] is high and the state returns to IDLE.
REQ-028 Latency: handshake in cycle T gives resp_valid in cycle T+RD_LAT+1; the next handshake is possible no earlier than cycle T+RD_LAT+2.
REQ-029 Round-robin: the search starts at (last_grant+1) mod N_CH and wraps; last_grant updates on each handshake and resets to N_CH-1, so channel 0 wins first.
REQ-030 Fixed priority: the lowest-indexed valid channel wins; last_grant is still tracked.
REQ-031 grant_cnt[i] increments on each handshake of channel i and saturates at 16'hFFFF.
REQ-032 A channel deasserting req_valid in ACCESS or RESP does not abort the transaction in flight.
REQ-033 Outside ACCESS, mem_addr and mem_wdata hold their last values, and mem_we is 0.
REQ-034 hold rising during ACCESS or RESP lets the transaction complete; the FSM then stalls in IDLE.

Reset
REQ-035 On rst: state IDLE, counter 0, last_grant N_CH-1, resp_valid 0, resp_rdata 0, mem_we 0, mem_addr 0, mem_wdata 0, all grant_cnt 0.
REQ-036 rst in ACCESS or RESP aborts the transaction: no resp_valid is issued, and mem_we is 0 from the next cycle.
REQ-037 rst has priority over every other input in the same cycle.

Structure
REQ-038 Package mem_arb_pkg holds the state enum (IDLE, ACCESS, RESP), the MODE_RR/MODE_FIXED constants and the counter width constant 16.
REQ-039 Sub-module arb_pick (N_CH, MODE) is purely combinational: it takes req vector, start index and mode, and returns a one-hot grant plus an index.
REQ-040 All packed-bus slicing uses [i*W +: W].

Verification
REQ-041 RD_LAT=1, ch1 read at addr 0x40, mem_rdata=0xDEAD_BEEF -> req_ready[1] in cycle T, mem_addr=0x40 in T+1, resp_valid[1] and resp_rdata=0xDEADBEEF in T+2.
REQ-042 MODE=0, all 3 channels held valid for 9 grants -> grant order 0,1,2,0,1,2,0,1,2 and grant_cnt=3 for each channel.
REQ-043 MODE=1, ch0 and ch2 continuously valid -> only ch0 is granted; ch2 grant_cnt stays 0.
REQ-044 RD_LAT=3, ch2 write 0x1234 to 0x80 -> mem_we high for exactly 1 cycle, resp_valid[2] at T+4, resp_rdata unchanged.
REQ-045 rst asserted in the 2nd ACCESS cycle (RD_LAT=3) -> no resp_valid; state, counters and last_grant at reset values next cycle.
REQ-046 hold high with ch0 valid for 5 cycles -> req_ready stays 0; hold low -> req_ready[0] in that same cycle; grant_cnt preloaded to 0xFFFF then one more grant -> stays 0xFFFF.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam int unsigned MODE_RR    = 0;
  localparam int unsigned MODE_FIXED = 1;
  localparam int unsigned CNT_W      = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM-port bundle between requesters and the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);

  logic [N_CH-1:0]        req_valid;
  logic [N_CH-1:0]        req_we;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*DATA_W-1:0] req_wdata;
  logic [N_CH-1:0]        req_ready;
  logic [N_CH-1:0]        resp_valid;
  logic [DATA_W-1:0]      resp_rdata;
  logic                   mem_we;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_wdata;
  logic [DATA_W-1:0]      mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner selection: circular search from i_start (round-robin)
// or from index 0 (fixed priority).
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH = 3,
  parameter int unsigned MODE = MODE_RR,
  localparam int unsigned IDX_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N_CH-1:0]  o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic [IDX_W-1:0] w_base;
  logic [IDX_W-1:0] w_pos;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    w_base  = (MODE == MODE_FIXED) ? '0 : i_start;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_pos = IDX_W'((32'(w_base) + k) % N_CH);
      if (!w_found && i_req[w_pos]) begin
        o_grant[w_pos] = 1'b1;
        o_idx          = w_pos;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port among N_CH requesters: IDLE -> ACCESS (RD_LAT cycles) -> RESP.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH   = 3,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned MODE   = MODE_RR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_hold,
  mem_port_arbiter_if.slave     bus,
  output logic                  o_busy,
  output logic [N_CH*CNT_W-1:0] o_grant_cnt
);

  localparam int unsigned IDX_W = $clog2(N_CH);
  localparam int unsigned LAT_W = 2;

  state_e                       r_state, w_state_nxt;
  logic [LAT_W-1:0]             r_lat_cnt;
  logic [IDX_W-1:0]             r_last;
  logic [N_CH-1:0]              r_gnt_oh;
  logic                         r_we;
  logic [ADDR_W-1:0]            r_addr;
  logic [DATA_W-1:0]            r_wdata;
  logic [DATA_W-1:0]            r_rdata;
  logic [N_CH-1:0][CNT_W-1:0]   r_grant_cnt;

  logic [IDX_W-1:0]             w_start, w_pick_idx;
  logic [N_CH-1:0]              w_pick_oh, w_ready;
  logic                         w_hs, w_lat_done;

  assign w_start    = (r_last == IDX_W'(N_CH - 1)) ? '0 : r_last + 1'b1;
  assign w_lat_done = (r_lat_cnt == '0);
  assign w_hs       = |w_ready;

  arb_pick #(
    .N_CH (N_CH),
    .MODE (MODE)
  ) u_pick (
    .i_req   (bus.req_valid),
    .i_start (w_start),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    unique case (r_state)
      IDLE: begin
        if (!i_hold && |bus.req_valid) begin
          w_ready     = w_pick_oh;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS:  if (w_lat_done) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_lat_cnt   <= '0;
      r_last      <= IDX_W'(N_CH - 1);
      r_gnt_oh    <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_grant_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hs) begin
        r_last    <= w_pick_idx;
        r_gnt_oh  <= w_pick_oh;
        r_we      <= bus.req_we[w_pick_idx];
        r_addr    <= bus.req_addr[w_pick_idx*ADDR_W +: ADDR_W];
        r_wdata   <= bus.req_wdata[w_pick_idx*DATA_W +: DATA_W];
        r_lat_cnt <= LAT_W'(RD_LAT - 1);
        if (r_grant_cnt[w_pick_idx] != '1) begin
          r_grant_cnt[w_pick_idx] <= r_grant_cnt[w_pick_idx] + 1'b1;
        end
      end else if (r_state == ACCESS && !w_lat_done) begin
        r_lat_cnt <= r_lat_cnt - 1'b1;
      end
      // Read data is captured on the final ACCESS cycle; writes leave it untouched.
      if (r_state == ACCESS && w_lat_done && !r_we) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  // First ACCESS cycle is the one where the counter still holds its load value.
  assign bus.mem_we     = (r_state == ACCESS) && r_we && (r_lat_cnt == LAT_W'(RD_LAT - 1));
  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = (r_state == RESP) ? r_gnt_oh : '0;
  assign bus.resp_rdata = r_rdata;
  assign o_busy         = (r_state != IDLE);
  assign o_grant_cnt    = r_grant_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, round-robin, fixed priority,
// write timing, reset abort, hold and counter saturation.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic hold;
  logic busy_a, busy_b, busy_c;
  logic [47:0] gcnt_a, gcnt_b, gcnt_c;
  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_CH(3), .ADDR_W(64), .DATA_W(64)) bus_a ();
  mem_port_arbiter_if #(.N_CH(3), .ADDR_W(64), .DATA_W(64)) bus_b ();
  mem_port_arbiter_if #(.N_CH(3), .ADDR_W(64), .DATA_W(64)) bus_c ();

  mem_port_arbiter #(.N_CH(3), .ADDR_W(64), .DATA_W(64), .RD_LAT(1), .MODE(0)) u_a (
    .clk(clk), .rst(rst), .i_hold(hold), .bus(bus_a), .o_busy(busy_a), .o_grant_cnt(gcnt_a)
  );
  mem_port_arbiter #(.N_CH(3), .ADDR_W(64), .DATA_W(64), .RD_LAT(1), .MODE(1)) u_b (
    .clk(clk), .rst(rst), .i_hold(hold), .bus(bus_b), .o_busy(busy_b), .o_grant_cnt(gcnt_b)
  );
  mem_port_arbiter #(.N_CH(3), .ADDR_W(64), .DATA_W(64), .RD_LAT(3), .MODE(0)) u_c (
    .clk(clk), .rst(rst), .i_hold(hold), .bus(bus_c), .o_busy(busy_c), .o_grant_cnt(gcnt_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  logic [2:0] rr_order [9] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100,
                               3'b001, 3'b010, 3'b100};

  initial begin
    rst  = 1'b1;
    hold = 1'b0;
    bus_a.req_valid = '0; bus_a.req_we = '0; bus_a.req_addr = '0; bus_a.req_wdata = '0;
    bus_a.mem_rdata = '0;
    bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0; bus_b.req_wdata = '0;
    bus_b.mem_rdata = '0;
    bus_c.req_valid = '0; bus_c.req_we = '0; bus_c.req_addr = '0; bus_c.req_wdata = '0;
    bus_c.mem_rdata = '0;
    tick();
    tick();
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_resp_valid", 64'(bus_a.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus_a.resp_rdata, 64'd0);
    chk("rst_mem_we", 64'(bus_a.mem_we), 64'd0);
    chk("rst_mem_addr", bus_a.mem_addr, 64'd0);
    chk("rst_grant_cnt", 64'(gcnt_a), 64'd0);
    rst = 1'b0;

    // ch1 read at 0x40, RD_LAT=1
    bus_a.req_valid = 3'b010;
    bus_a.req_addr[1*64 +: 64] = 64'h40;
    bus_a.mem_rdata = 64'hDEAD_BEEF;
    #1;
    chk("t1_ready_T", 64'(bus_a.req_ready), 64'h2);
    tick();
    bus_a.req_valid = '0;
    #1;
    chk("t1_addr_T1", bus_a.mem_addr, 64'h40);
    chk("t1_busy_T1", 64'(busy_a), 64'd1);
    chk("t1_ready_T1", 64'(bus_a.req_ready), 64'd0);
    chk("t1_rv_T1", 64'(bus_a.resp_valid), 64'd0);
    chk("t1_we_T1", 64'(bus_a.mem_we), 64'd0);
    tick();
    chk("t1_rv_T2", 64'(bus_a.resp_valid), 64'h2);
    chk("t1_rdata_T2", bus_a.resp_rdata, 64'hDEAD_BEEF);
    tick();
    chk("t1_idle_T3", 64'(busy_a), 64'd0);
    chk("t1_rv_T3", 64'(bus_a.resp_valid), 64'd0);

    // Round-robin with all three requesting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_a.req_valid = 3'b111;
    for (int g = 0; g < 9; g++) begin
      #1;
      chk($sformatf("rr_ready_%0d", g), 64'(bus_a.req_ready), 64'(rr_order[g]));
      tick();
      tick();
      chk($sformatf("rr_resp_%0d", g), 64'(bus_a.resp_valid), 64'(rr_order[g]));
      tick();
    end
    bus_a.req_valid = '0;
    #1;
    chk("rr_grant_cnt", 64'(gcnt_a), 64'h0003_0003_0003);

    // Fixed priority: ch0 and ch2 both requesting
    bus_b.req_valid = 3'b101;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk($sformatf("fx_ready_%0d", g), 64'(bus_b.req_ready), 64'h1);
      tick();
      chk($sformatf("fx_busy_%0d", g), 64'(busy_b), 64'd1);
      tick();
      tick();
    end
    bus_b.req_valid = '0;
    #1;
    chk("fx_grant_cnt", 64'(gcnt_b), 64'h0000_0000_0004);

    // ch2 write, RD_LAT=3
    bus_c.mem_rdata = 64'hCAFE;
    bus_c.req_valid = 3'b100;
    bus_c.req_we    = 3'b100;
    bus_c.req_addr[2*64 +: 64]  = 64'h80;
    bus_c.req_wdata[2*64 +: 64] = 64'h1234;
    #1;
    chk("wr_ready_T", 64'(bus_c.req_ready), 64'h4);
    chk("wr_we_T", 64'(bus_c.mem_we), 64'd0);
    tick();
    bus_c.req_valid = '0;
    bus_c.req_we    = '0;
    #1;
    chk("wr_we_T1", 64'(bus_c.mem_we), 64'd1);
    chk("wr_addr_T1", bus_c.mem_addr, 64'h80);
    chk("wr_wdata_T1", bus_c.mem_wdata, 64'h1234);
    tick();
    chk("wr_we_T2", 64'(bus_c.mem_we), 64'd0);
    chk("wr_addr_T2", bus_c.mem_addr, 64'h80);
    tick();
    chk("wr_we_T3", 64'(bus_c.mem_we), 64'd0);
    chk("wr_rv_T3", 64'(bus_c.resp_valid), 64'd0);
    tick();
    chk("wr_rv_T4", 64'(bus_c.resp_valid), 64'h4);
    chk("wr_rdata_T4", bus_c.resp_rdata, 64'd0);
    tick();
    chk("wr_idle_T5", 64'(busy_c), 64'd0);
    chk("wr_addr_T5", bus_c.mem_addr, 64'h80);

    // Reset during the second ACCESS cycle of a ch0 read
    bus_c.req_valid = 3'b001;
    bus_c.req_addr[0*64 +: 64] = 64'h100;
    #1;
    chk("ab_ready_T", 64'(bus_c.req_ready), 64'h1);
    tick();
    bus_c.req_valid = '0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("ab_busy", 64'(busy_c), 64'd0);
    chk("ab_rv_T3", 64'(bus_c.resp_valid), 64'd0);
    chk("ab_mem_we", 64'(bus_c.mem_we), 64'd0);
    chk("ab_mem_addr", bus_c.mem_addr, 64'd0);
    chk("ab_rdata", bus_c.resp_rdata, 64'd0);
    chk("ab_grant_cnt", 64'(gcnt_c), 64'd0);
    tick();
    chk("ab_rv_T4", 64'(bus_c.resp_valid), 64'd0);
    bus_c.req_valid = 3'b111;
    #1;
    chk("ab_last_grant", 64'(bus_c.req_ready), 64'h1);
    tick();
    bus_c.req_valid = '0;
    repeat (4) tick();

    // hold freezes new grants
    hold = 1'b1;
    bus_a.req_valid = 3'b001;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("hold_ready_%0d", c), 64'(bus_a.req_ready), 64'd0);
      tick();
    end
    chk("hold_busy", 64'(busy_a), 64'd0);
    hold = 1'b0;
    #1;
    chk("hold_release", 64'(bus_a.req_ready), 64'h1);
    tick();
    bus_a.req_valid = '0;
    tick();
    tick();
    chk("hold_grant_cnt", 64'(gcnt_a), 64'h0000_0000_0001);

    // Saturation at 0xFFFF
    force u_a.r_grant_cnt = 48'h0000_0000_FFFF;
    tick();
    release u_a.r_grant_cnt;
    #1;
    chk("sat_preload", 64'(gcnt_a), 64'h0000_0000_FFFF);
    bus_a.req_valid = 3'b001;
    #1;
    chk("sat_ready", 64'(bus_a.req_ready), 64'h1);
    tick();
    bus_a.req_valid = '0;
    tick();
    tick();
    chk("sat_grant_cnt", 64'(gcnt_a), 64'h0000_0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
